// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state type and sizing helpers for the clock divider and
// clock ratio meter family.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    MEAS = 2'd2
  } meas_state_e;

  localparam int DIV_RATIO_WD_DEFAULT = 8;

  // Largest count that fits a ratio field of the given width.
  function automatic int max_count(input int wd);
    return (1 << wd) - 1;
  endfunction

endpackage

// File: rtl/clk_ratio_meter_if.sv
// clk_ratio_meter_if: control and result signals of the clock ratio meter.
// master = the side that enables the meter and supplies the clock under test,
// slave = the meter itself.
interface clk_ratio_meter_if
  import clk_div_pkg::*;
#(
  parameter int div_ratio_wd = DIV_RATIO_WD_DEFAULT
);
  logic                    meas_en;
  logic                    clk_in;
  logic [div_ratio_wd-1:0] div_ratio;
  logic [div_ratio_wd-1:0] high_cnt;
  logic [div_ratio_wd-1:0] low_cnt;
  logic                    meas_done;
  logic                    ratio_valid;
  logic                    timeout;
  logic                    locked;

  modport master (
    output meas_en, clk_in,
    input  div_ratio, high_cnt, low_cnt, meas_done, ratio_valid, timeout, locked
  );

  modport slave (
    input  meas_en, clk_in,
    output div_ratio, high_cnt, low_cnt, meas_done, ratio_valid, timeout, locked
  );
endinterface

// File: rtl/clk_edge_det.sv
// clk_edge_det: one-bit sample register with rising/falling edge flags, for
// clock monitors that treat a clock as data.
module clk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic prev;

  // Remember the previous sample; reset clears it to 0.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= d;
  end

  assign rise = d & ~prev;
  assign fall = ~d & prev;
endmodule

// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: samples a divided clock on clk_ref and recovers its integer
// division ratio plus high/low phase widths, measured back to back.
// Optional lock detector: define CLK_RATIO_METER_LOCK_EN.
module clk_ratio_meter
  import clk_div_pkg::*;
#(
  parameter int div_ratio_wd = DIV_RATIO_WD_DEFAULT,
  parameter int LOCK_CNT     = 3
) (
  input logic              clk_ref,
  input logic              rst,
  clk_ratio_meter_if.slave bus
);
  localparam logic [div_ratio_wd:0]   MAX_SUM = (div_ratio_wd+1)'(max_count(div_ratio_wd));
  localparam logic [div_ratio_wd-1:0] ONE     = (div_ratio_wd)'(1);

  if (LOCK_CNT < 1) begin : g_bad_lock_cnt
    $error("clk_ratio_meter: LOCK_CNT must be at least 1");
  end

  meas_state_e             state, state_nxt;
  logic [div_ratio_wd-1:0] hcnt, lcnt, hcnt_nxt, lcnt_nxt;
  logic [div_ratio_wd-1:0] ratio_q, high_q, low_q;
  logic [div_ratio_wd-1:0] ratio_nxt, high_nxt, low_nxt;
  logic                    done_q, valid_q, timeout_q;
  logic                    done_nxt, valid_nxt, timeout_nxt;
  logic [div_ratio_wd:0]   sum;
  logic                    rise;
  logic                    fall_unused;

  clk_edge_det u_edge (
    .clk  (clk_ref),
    .rst  (rst),
    .d    (bus.clk_in),
    .rise (rise),
    .fall (fall_unused)
  );

  // One bit wider than the counters; the timeout keeps the real sum in range.
  assign sum = {1'b0, hcnt} + {1'b0, lcnt};

  // Next state and datapath: sync to a rising edge, then count phases and
  // publish on every following rising edge.
  always_comb begin
    state_nxt   = state;
    hcnt_nxt    = hcnt;
    lcnt_nxt    = lcnt;
    ratio_nxt   = ratio_q;
    high_nxt    = high_q;
    low_nxt     = low_q;
    done_nxt    = 1'b0;
    valid_nxt   = valid_q;
    timeout_nxt = timeout_q;
    if (!bus.meas_en) begin
      state_nxt   = IDLE;
      valid_nxt   = 1'b0;
      timeout_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: state_nxt = SYNC;
        SYNC: begin
          if (rise) begin
            hcnt_nxt  = ONE;
            lcnt_nxt  = '0;
            state_nxt = MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            ratio_nxt   = sum[div_ratio_wd-1:0];
            high_nxt    = hcnt;
            low_nxt     = lcnt;
            done_nxt    = 1'b1;
            valid_nxt   = 1'b1;
            timeout_nxt = 1'b0;
            hcnt_nxt    = ONE;
            lcnt_nxt    = '0;
          end else if (sum == MAX_SUM) begin
            timeout_nxt = 1'b1;
            valid_nxt   = 1'b0;
            state_nxt   = SYNC;
          end else if (bus.clk_in) begin
            hcnt_nxt = hcnt + ONE;
          end else begin
            lcnt_nxt = lcnt + ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state     <= IDLE;
      hcnt      <= '0;
      lcnt      <= '0;
      ratio_q   <= '0;
      high_q    <= '0;
      low_q     <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      lcnt      <= lcnt_nxt;
      ratio_q   <= ratio_nxt;
      high_q    <= high_nxt;
      low_q     <= low_nxt;
      done_q    <= done_nxt;
      valid_q   <= valid_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign bus.div_ratio   = ratio_q;
  assign bus.high_cnt    = high_q;
  assign bus.low_cnt     = low_q;
  assign bus.meas_done   = done_q;
  assign bus.ratio_valid = valid_q;
  assign bus.timeout     = timeout_q;

`ifdef CLK_RATIO_METER_LOCK_EN
  localparam int              MW        = $clog2(LOCK_CNT) + 1;
  localparam logic [MW-1:0]   MATCH_TGT = MW'(LOCK_CNT - 1);

  logic [MW-1:0] match_q, match_nxt;
  logic          locked_q, locked_nxt;
  logic          publish, abandon, same;

  // A stale ratio (after abort or timeout) never counts as a match: valid_q
  // is low until the first fresh result.
  assign publish = bus.meas_en && (state == MEAS) && rise;
  assign abandon = !bus.meas_en || ((state == MEAS) && !rise && (sum == MAX_SUM));
  assign same    = valid_q && (sum[div_ratio_wd-1:0] == ratio_q);

  // Count consecutive identical periods; lock once LOCK_CNT in a row agree.
  always_comb begin
    match_nxt  = match_q;
    locked_nxt = locked_q;
    if (abandon) begin
      match_nxt  = '0;
      locked_nxt = 1'b0;
    end else if (publish) begin
      if (!same) begin
        match_nxt  = '0;
        locked_nxt = 1'b0;
      end else begin
        if (match_q != MATCH_TGT) match_nxt = match_q + MW'(1);
        locked_nxt = (match_nxt == MATCH_TGT);
      end
    end
  end

  // Lock detector registers.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      match_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      match_q  <= match_nxt;
      locked_q <= locked_nxt;
    end
  end

  assign bus.locked = locked_q;
`else
  assign bus.locked = 1'b0;
`endif

endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb_clk_ratio_meter: vector table for the first measurement, hand-written
// corner sequences and randomized divider traffic against a queue-based model.
module tb_clk_ratio_meter;
  localparam int WD       = 8;
  localparam int LOCK_CNT = 3;
  localparam int MAXC     = (1 << WD) - 1;

  typedef struct packed {
    logic [WD-1:0] ratio;
    logic [WD-1:0] high;
    logic [WD-1:0] low;
    logic          done;
    logic          valid;
    logic          timeout;
    logic          locked;
  } out_t;

  typedef struct {
    bit   rst;
    bit   en;
    bit   cin;
    out_t exp;
  } vec_t;

  typedef enum {M_OFF, M_WAIT, M_RUN} mmode_e;

  logic clk_ref = 1'b0;
  logic rst     = 1'b1;

  clk_ratio_meter_if #(.div_ratio_wd(WD)) bus ();

  clk_ratio_meter #(.div_ratio_wd(WD), .LOCK_CNT(LOCK_CNT)) dut (
    .clk_ref (clk_ref),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 clk_ref = ~clk_ref;

  int n_cmp     = 0;
  int n_fail    = 0;
  int done_seen = 0;

  // Reference model: samples since the last rising edge kept in a queue,
  // published ratios since the last loss of validity kept in a history.
  mmode_e m_mode = M_OFF;
  bit     m_prev = 1'b0;
  bit     m_samples[$];
  int     m_hist[$];
  out_t   m_out = '0;

  function automatic bit lock_now();
`ifdef CLK_RATIO_METER_LOCK_EN
    if (m_hist.size() < LOCK_CNT) return 1'b0;
    for (int i = m_hist.size() - LOCK_CNT; i < m_hist.size() - 1; i++)
      if (m_hist[i] != m_hist[i+1]) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_step(input bit r, input bit e, input bit s);
    bit rise = s && !m_prev;
    int h = 0;
    m_out.done = 1'b0;
    if (r) begin
      m_mode = M_OFF;
      m_out  = '0;
      m_samples.delete();
      m_hist.delete();
      m_prev = 1'b0;
      return;
    end
    if (!e) begin
      m_mode        = M_OFF;
      m_out.valid   = 1'b0;
      m_out.timeout = 1'b0;
      m_samples.delete();
      m_hist.delete();
    end else begin
      case (m_mode)
        M_OFF:  m_mode = M_WAIT;
        M_WAIT: if (rise) begin
          m_samples = {1'b1};
          m_mode    = M_RUN;
        end
        M_RUN: begin
          if (rise) begin
            foreach (m_samples[i]) if (m_samples[i]) h++;
            m_out.ratio   = WD'(m_samples.size());
            m_out.high    = WD'(h);
            m_out.low     = WD'(m_samples.size() - h);
            m_out.done    = 1'b1;
            m_out.valid   = 1'b1;
            m_out.timeout = 1'b0;
            m_hist.push_back(m_samples.size());
            m_samples = {1'b1};
          end else if (m_samples.size() == MAXC) begin
            m_out.timeout = 1'b1;
            m_out.valid   = 1'b0;
            m_hist.delete();
            m_samples.delete();
            m_mode = M_WAIT;
          end else begin
            m_samples.push_back(s);
          end
        end
        default: m_mode = M_OFF;
      endcase
    end
    m_prev       = s;
    m_out.locked = lock_now();
  endfunction

  function automatic out_t actual();
    out_t a;
    a.ratio   = bus.div_ratio;
    a.high    = bus.high_cnt;
    a.low     = bus.low_cnt;
    a.done    = bus.meas_done;
    a.valid   = bus.ratio_valid;
    a.timeout = bus.timeout;
    a.locked  = bus.locked;
    return a;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("ratio=%0d high=%0d low=%0d done=%0b valid=%0b timeout=%0b locked=%0b",
                     o.ratio, o.high, o.low, o.done, o.valid, o.timeout, o.locked);
  endfunction

  function automatic vec_t mk(input bit r, input bit e, input bit c, input int ratio,
                              input int high, input int low, input bit done, input bit valid);
    vec_t v;
    v.rst       = r;
    v.en        = e;
    v.cin       = c;
    v.exp       = '0;
    v.exp.ratio = WD'(ratio);
    v.exp.high  = WD'(high);
    v.exp.low   = WD'(low);
    v.exp.done  = done;
    v.exp.valid = valid;
    return v;
  endfunction

  task automatic applyStimulus(input bit r, input bit e, input bit c);
    @(negedge clk_ref);
    rst         = r;
    bus.meas_en = e;
    bus.clk_in  = c;
    @(posedge clk_ref);
    #1;
    model_step(r, e, c);
    done_seen += int'(bus.meas_done);
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %s, want %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit c, input string name = "model");
    applyStimulus(r, e, c);
    checkOutput(name, m_out);
  endtask

  // Divider output: floor(n/2) cycles high then the rest low, per period.
  task automatic run_div(input int n, input int periods);
    for (int p = 0; p < periods; p++)
      for (int i = 0; i < n; i++)
        step(1'b0, 1'b1, (i < n / 2), $sformatf("div%0d", n));
  endtask

  initial begin
    vec_t tbl[16];
    int   to_at;
    bus.meas_en = 1'b0;
    bus.clk_in  = 1'b0;

    // Reset, sync and the first two ratio-4 results, then meas_en drop.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 1, 4, 2, 2, 1, 1);
    tbl[10] = mk(0, 1, 1, 4, 2, 2, 0, 1);
    tbl[11] = mk(0, 1, 0, 4, 2, 2, 0, 1);
    tbl[12] = mk(0, 1, 0, 4, 2, 2, 0, 1);
    tbl[13] = mk(0, 1, 1, 4, 2, 2, 1, 1);
    tbl[14] = mk(0, 0, 1, 4, 2, 2, 0, 0);
    tbl[15] = mk(0, 0, 0, 4, 2, 2, 0, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].cin);
      checkOutput($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Ratio 4: one meas_done per 4 cycles.
    step(1'b0, 1'b1, 1'b0);
    run_div(4, 2);
    checkValue("r4_ratio", int'(bus.div_ratio), 4);
    checkValue("r4_high", int'(bus.high_cnt), 2);
    checkValue("r4_low", int'(bus.low_cnt), 2);
    done_seen = 0;
    run_div(4, 4);
    checkValue("r4_done_pulses", done_seen, 4);
    checkValue("r4_valid", int'(bus.ratio_valid), 1);

    // Odd ratio.
    run_div(5, 3);
    checkValue("r5_ratio", int'(bus.div_ratio), 5);
    checkValue("r5_high", int'(bus.high_cnt), 2);
    checkValue("r5_low", int'(bus.low_cnt), 3);

    // Largest measurable ratio, then a stuck-low input times out at 255.
    run_div(255, 2);
    step(1'b0, 1'b1, 1'b1);
    checkValue("r255_ratio", int'(bus.div_ratio), 255);
    checkValue("r255_high", int'(bus.high_cnt), 127);
    checkValue("r255_low", int'(bus.low_cnt), 128);
    checkValue("r255_no_timeout", int'(bus.timeout), 0);
    to_at = 0;
    for (int k = 1; k <= 260; k++) begin
      step(1'b0, 1'b1, 1'b0, "hold_low");
      if (to_at == 0 && bus.timeout) to_at = k;
    end
    checkValue("timeout_at_count", to_at, 255);
    checkValue("timeout_valid", int'(bus.ratio_valid), 0);
    checkValue("timeout_keeps_ratio", int'(bus.div_ratio), 255);

    // Ratio change 6 -> 3.
    run_div(6, 5);
`ifdef CLK_RATIO_METER_LOCK_EN
    checkValue("lock_at_6", int'(bus.locked), 1);
`endif
    run_div(3, 2);
    checkValue("r3_ratio", int'(bus.div_ratio), 3);
    checkValue("r3_high", int'(bus.high_cnt), 1);
    checkValue("r3_low", int'(bus.low_cnt), 2);
`ifdef CLK_RATIO_METER_LOCK_EN
    checkValue("lock_drop_on_change", int'(bus.locked), 0);
`endif
    run_div(3, 3);
`ifdef CLK_RATIO_METER_LOCK_EN
    checkValue("lock_reacquired", int'(bus.locked), 1);
`endif

    // clk_in stuck high from reset: waits in sync forever.
    step(1'b1, 1'b1, 1'b1);
    checkOutput("stuck_reset_zero", '0);
    repeat (300) step(1'b0, 1'b1, 1'b1, "stuck_high");
    checkValue("stuck_valid", int'(bus.ratio_valid), 0);
    checkValue("stuck_timeout", int'(bus.timeout), 0);

    // Reset mid-period at ratio 8, then full resynchronisation.
    run_div(8, 4);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    checkOutput("mid_reset_zero", '0);
    run_div(8, 4);
    checkValue("r8_ratio", int'(bus.div_ratio), 8);
    checkValue("r8_high", int'(bus.high_cnt), 4);
    checkValue("r8_low", int'(bus.low_cnt), 4);

    // meas_en dropped mid-period, then re-enabled.
    repeat (2) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    checkValue("drop_valid", int'(bus.ratio_valid), 0);
    checkValue("drop_no_done", int'(bus.meas_done), 0);
    run_div(4, 3);
    checkValue("reenable_valid", int'(bus.ratio_valid), 1);
    checkValue("reenable_ratio", int'(bus.div_ratio), 4);

    // Randomized traffic: divider runs, noise with meas_en toggling, resets.
    for (int seg = 0; seg < 40; seg++) begin
      int r;
      int n;
      r = int'($urandom_range(0, 15));
      if (r == 0) begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_reset");
      end else if (r <= 2) begin
        repeat ($urandom_range(1, 6))
          step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_noise");
      end else begin
        n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 262))
                                        : int'($urandom_range(2, 12));
        run_div(n, int'($urandom_range(1, 4)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no end of test, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
